// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serial transmitter: FSM encoding and
// the bit-counter width helper.
package piso_tx_pkg;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // The counter must reach WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Control/status bundle of piso_tx; the slave modport is the transmitter side.
interface piso_tx_if
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  // Handshake: a load is taken only on a cycle with en=1 while idle or on the
  // last bit of a word (done=1); any other load is dropped, nothing is queued.
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             pr;
  logic             ps;
  logic             q;
  logic             busy;
  logic             done;
  state_t           state;

  modport master (
    output en, load, data, pr, ps,
    input  q, busy, done, state
  );

  modport slave (
    input  en, load, data, pr, ps,
    output q, busy, done, state
  );

endinterface

// File: rtl/piso_tx_shreg_en.sv
// WIDTH-bit shift register with enable, sync clear (ps), sync set (pr) and
// parallel load; exposes the bit that will be sent after the current one.
module shreg_en #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pr,
  input  logic             ps,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] din,
  output logic             nxt
);

  logic [WIDTH-1:0] sreg;

  // Same priority as the single D cells: rst > ps > pr > enabled operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (ps) begin
      sreg <= '0;
    end else if (pr) begin
      sreg <= '1;
    end else if (en) begin
      if (ld) begin
        sreg <= din;
      end else if (sh) begin
        sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

  assign nxt = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on load and shifts it
// out on q one bit per enabled clock, with busy and a last-bit done pulse.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  piso_tx_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          q_r;
  logic          last;
  logic          accept;
  logic          shift;
  logic          first_bit;
  logic          next_bit;

  // cnt holds the index (1-based) of the bit currently on q.
  assign last      = (state == ST_SHIFT) && (cnt == CW'(WIDTH));
  assign accept    = bus.en && bus.load && ((state == ST_IDLE) || last);
  assign shift     = bus.en && (state == ST_SHIFT) && !last;
  assign first_bit = MSB_FIRST ? bus.data[WIDTH-1] : bus.data[0];

  shreg_en #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .pr  (bus.pr),
    .ps  (bus.ps),
    .ld  (accept),
    .sh  (shift),
    .din (bus.data),
    .nxt (next_bit)
  );

  // After pr/ps, q keeps the forced level until the next accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q_r   <= IDLE_LVL;
    end else if (bus.ps) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q_r   <= 1'b0;
    end else if (bus.pr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q_r   <= 1'b1;
    end else if (accept) begin
      state <= ST_SHIFT;
      cnt   <= CW'(1);
      q_r   <= first_bit;
    end else if (shift) begin
      cnt   <= cnt + CW'(1);
      q_r   <= next_bit;
    end else if (last && bus.en) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q_r   <= IDLE_LVL;
    end
  end

  // A frozen (en=0) or aborted last bit does not count as completion.
  assign bus.done  = last && bus.en && !rst && !bus.pr && !bus.ps;
  assign bus.busy  = (state == ST_SHIFT);
  assign bus.q     = q_r;
  assign bus.state = state;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share stimulus and
// are checked against a queue-based model, literal vector tables and sequences.
module tb_piso_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(8)) m_if ();
  piso_tx_if #(.WIDTH(8)) l_if ();

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_m (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (l_if)
  );

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Reference model: the word in flight plus a queue of bit positions still
  // to be sent (MSB-first order; the LSB-first view mirrors the position).
  logic [7:0] mword = '0;
  logic [2:0] cur   = '0;
  logic [2:0] exp_q[$];
  bit         mact  = 1'b0;
  logic       mlvl  = 1'b0;

  typedef struct {
    logic r, e, l, p, s;
    logic [7:0] d;
    logic eq, eb, ed;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, e, l, p, s, input logic [7:0] d);
    logic eqm, eql, edn;
    @(negedge clk);
    rst = r;
    m_if.en = e; m_if.load = l; m_if.pr = p; m_if.ps = s; m_if.data = d;
    l_if.en = e; l_if.load = l; l_if.pr = p; l_if.ps = s; l_if.data = d;
    #1;
    if (armed) begin
      eqm = mact ? mword[cur] : mlvl;
      eql = mact ? mword[3'd7 - cur] : mlvl;
      edn = mact && (exp_q.size() == 0) && e && !r && !p && !s;
      chk("m_q", m_if.q, eqm);
      chk("m_busy", m_if.busy, mact);
      chk("m_done", m_if.done, edn);
      chk("l_q", l_if.q, eql);
      chk("l_busy", l_if.busy, mact);
      chk("l_done", l_if.done, edn);
    end
  endtask

  task automatic tick();
    logic r, e, l, p, s;
    logic [7:0] d;
    bit last;
    @(posedge clk);
    r = rst; e = m_if.en; l = m_if.load; p = m_if.pr; s = m_if.ps; d = m_if.data;
    last = mact && (exp_q.size() == 0);
    if (r) begin
      mact = 1'b0; exp_q.delete(); mlvl = 1'b0;
    end else if (s) begin
      mact = 1'b0; exp_q.delete(); mlvl = 1'b0;
    end else if (p) begin
      mact = 1'b0; exp_q.delete(); mlvl = 1'b1;
    end else if (e) begin
      if (l && (!mact || last)) begin
        mword = d;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        cur  = exp_q.pop_front();
        mact = 1'b1;
      end else if (last) begin
        mact = 1'b0; mlvl = 1'b0;
      end else if (mact) begin
        cur = exp_q.pop_front();
      end
    end
  endtask

  task automatic add(input logic r, e, l, p, s, input logic [7:0] d,
                     input logic eq, eb, ed);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.p = p; v.s = s; v.d = d;
    v.eq = eq; v.eb = eb; v.ed = ed;
    tv.push_back(v);
  endtask

  initial begin
    logic [7:0] c3;
    int ndone;
    logic r, e, l, p, s;
    logic [7:0] d;

    // reset and idle (outputs are unknown before the first reset edge)
    add(1,0,0,0,0,8'h00, 0,0,0);
    add(0,0,0,0,0,8'h00, 0,0,0);
    add(0,1,0,0,0,8'h00, 0,0,0);
    add(0,1,0,0,0,8'h00, 0,0,0);
    // A5, MSB first
    add(0,1,1,0,0,8'hA5, 0,0,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 1,1,1);
    add(0,1,0,0,0,8'h00, 0,0,0);
    // F0 then 0F loaded on the done cycle
    add(0,1,1,0,0,8'hF0, 0,0,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,1,0,0,8'h0F, 0,1,1);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 1,1,1);
    add(0,1,0,0,0,8'h00, 0,0,0);
    // 55 aborted by pr, then ps, then pr+ps together
    add(0,1,1,0,0,8'h55, 0,0,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(0,1,0,1,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 1,0,0); add(0,0,0,0,0,8'h00, 1,0,0);
    add(0,0,0,0,1,8'h00, 1,0,0);
    add(0,1,0,0,0,8'h00, 0,0,0);
    add(0,0,0,1,1,8'h00, 0,0,0);
    add(0,1,0,0,0,8'h00, 0,0,0);
    // rst mid-word with en=0, then 81
    add(0,1,1,0,0,8'h55, 0,0,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 1,1,0);
    add(1,0,0,0,0,8'h00, 0,1,0);
    add(0,0,0,0,0,8'h00, 0,0,0);
    add(0,1,1,0,0,8'h81, 0,0,0);
    add(0,1,0,0,0,8'h00, 1,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 0,1,0);
    add(0,1,0,0,0,8'h00, 0,1,0); add(0,1,0,0,0,8'h00, 1,1,1);
    add(0,1,0,0,0,8'h00, 0,0,0);

    // first reset edge: nothing to compare yet
    drive(1, 0, 0, 0, 0, 8'h00);
    tick();
    armed = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].e, tv[i].l, tv[i].p, tv[i].s, tv[i].d);
      chk($sformatf("vec%0d_q", i), m_if.q, tv[i].eq);
      chk($sformatf("vec%0d_busy", i), m_if.busy, tv[i].eb);
      chk($sformatf("vec%0d_done", i), m_if.done, tv[i].ed);
      tick();
    end

    // C3 LSB first with en toggling: each bit held two cycles
    c3 = 8'hC3;
    ndone = 0;
    drive(0, 1, 1, 0, 0, c3);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'(i % 2), 0, 0, 0, 8'h00);
      chk($sformatf("c3_q%0d", i), l_if.q, c3[i/2]);
      chk($sformatf("c3_busy%0d", i), l_if.busy, 1'b1);
      chk($sformatf("c3_done%0d", i), l_if.done, i == 15);
      if (l_if.done) ndone++;
      tick();
    end
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("c3_idle_q", l_if.q, 1'b0);
    chk("c3_idle_busy", l_if.busy, 1'b0);
    chk("c3_pulses", ndone == 1, 1'b1);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 2);
      d = 8'($urandom);
      drive(r, e, l, p, s, d);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
